// File: rtl/sysid_checker.sv
// Avalon-MM read master that reads the sysid ID and timestamp words and
// compares them against build-time constants, reporting sticky pass/mismatch flags.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'h2317_6247,
  parameter logic [31:0] EXPECTED_TS  = 32'h5205_2AC3,
  parameter int          CHECK_TS     = 1,
  parameter int          READ_LATENCY = 1,
  parameter int          AUTO_START   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, COMPARE} state_t;

  localparam logic [3:0] LAT = READ_LATENCY[3:0];

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       auto_pend;
  logic       cap_id, cap_ts;
  logic       idm, tsm;

  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
    cap_id   = 1'b0;
    cap_ts   = 1'b0;
    case (state)
      IDLE: if (start || auto_pend) begin
        state_nx = RD_ID;
        cnt_nx   = LAT;
      end
      RD_ID: if (cnt == 4'd0) begin
        cap_id   = 1'b1;
        state_nx = RD_TS;
        cnt_nx   = LAT;
      end
      RD_TS: if (cnt == 4'd0) begin
        cap_ts   = 1'b1;
        state_nx = COMPARE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign idm = (id_value != EXPECTED_ID);
  assign tsm = (ts_value != EXPECTED_TS);

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      auto_pend     <= (AUTO_START != 0);
      sysid_address <= 1'b0;
      sysid_read    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      id_mismatch   <= 1'b0;
      ts_mismatch   <= 1'b0;
      id_value      <= 32'd0;
      ts_value      <= 32'd0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      auto_pend     <= 1'b0;
      sysid_read    <= (state_nx == RD_ID) || (state_nx == RD_TS);
      sysid_address <= (state_nx == RD_TS);
      busy          <= (state_nx != IDLE);
      done          <= (state == COMPARE);
      if (cap_id) id_value <= sysid_readdata;
      if (cap_ts) ts_value <= sysid_readdata;
      if (state == COMPARE) begin
        id_mismatch <= idm;
        ts_mismatch <= tsm;
        pass        <= !idm && !((CHECK_TS != 0) && tsm);
      end
    end
  end

endmodule
